// File: rtl/cache_refill_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_refill_unit_if : cache-side and memory-side handshake bundle          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface cache_refill_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int INDEX_WIDTH = 4
);
  logic                   miss_req;
  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic                   miss_ready;
  logic                   fill_valid;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic [DATA_WIDTH-1:0]  fill_data;
  logic                   wr_req;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_ready;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   mem_ack;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   busy;

  // master = cache + memory environment, slave = the refill unit
  modport master (
    output miss_req, miss_addr, wr_req, wr_addr, wr_data, mem_ack, mem_rdata,
    input  miss_ready, fill_valid, fill_index, fill_tag, fill_data, wr_ready,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  miss_req, miss_addr, wr_req, wr_addr, wr_data, mem_ack, mem_rdata,
    output miss_ready, fill_valid, fill_index, fill_tag, fill_data, wr_ready,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_refill_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_refill_unit : miss refill engine with write-through FIFO buffer       |
// | Optional CACHE_RAW_FWD_EN: forward buffered store data to a matching miss.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module cache_refill_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  cache_refill_unit_if.slave bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WBUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DRAIN = 3'd2,
    READ  = 3'd3,
    FILL  = 3'd4,
    WRITE = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
  logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]   buf_addr_q [WBUF_DEPTH];
  logic [ADDR_WIDTH-1:0]   buf_addr_d [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]   buf_data_q [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]   buf_data_d [WBUF_DEPTH];

  logic w_full, w_empty, w_accept, w_push, w_ack, w_pop;

  assign w_full   = (count_q == C_FULL);
  assign w_empty  = (count_q == '0);
  assign w_accept = bus.miss_req && (state_q == IDLE);
  assign w_push   = bus.wr_req && bus.wr_ready;
  // An ack is only meaningful while a request is outstanding.
  assign w_ack    = bus.mem_ack && mem_req_q;

`ifdef CACHE_RAW_FWD_EN
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [PTR_W-1:0]      w_idx;

  // Walk oldest-to-youngest so the last match is the youngest store.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      w_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (buf_addr_q[w_idx] == miss_addr_q)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = buf_data_q[w_idx];
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_data_d = fill_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    head_d      = head_q;
    tail_d      = tail_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    w_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          miss_addr_d = bus.miss_addr;
          state_d     = CHECK;
        end else if (!w_empty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = buf_addr_q[head_q];
          mem_wdata_d = buf_data_q[head_q];
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (w_ack) begin
          w_pop     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      CHECK: begin
`ifdef CACHE_RAW_FWD_EN
        if (w_fwd_hit) begin
          fill_data_d = w_fwd_data;
          state_d     = FILL;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = miss_addr_q;
          state_d    = READ;
        end
`else
        if (w_empty) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = miss_addr_q;
          state_d    = READ;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = buf_addr_q[head_q];
          mem_wdata_d = buf_data_q[head_q];
          state_d     = DRAIN;
        end
`endif
      end
      DRAIN: begin
        // Each drain write is followed by a one-cycle request gap.
        if (mem_req_q) begin
          if (w_ack) begin
            w_pop     = 1'b1;
            mem_req_d = 1'b0;
            if (count_q == CNT_W'(1)) state_d = READ;
          end
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = buf_addr_q[head_q];
          mem_wdata_d = buf_data_q[head_q];
        end
      end
      READ: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = miss_addr_q;
        end else if (w_ack) begin
          fill_data_d = bus.mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (w_push) begin
      buf_addr_d[tail_q] = bus.wr_addr;
      buf_data_d[tail_q] = bus.wr_data;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (w_pop) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      fill_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      fill_data_q <= fill_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  assign bus.miss_ready = (state_q == IDLE);
  assign bus.wr_ready   = !w_full && ((state_q == IDLE) || (state_q == WRITE));
  assign bus.fill_valid = (state_q == FILL);
  assign bus.fill_index = miss_addr_q[INDEX_WIDTH-1:0];
  assign bus.fill_tag   = miss_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign bus.fill_data  = fill_data_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = (state_q != IDLE) || !w_empty;
endmodule
`default_nettype wire

// File: tb/tb_cache_refill_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cache_refill_unit : directed self-checking bench for cache_refill_unit   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_cache_refill_unit;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  cache_refill_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TAG_WIDTH(8), .INDEX_WIDTH(4)) bus ();

  cache_refill_unit #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .TAG_WIDTH(8), .INDEX_WIDTH(4), .WBUF_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait for a request, hold ack low dly cycles, then ack for one cycle.
  task automatic mem_serve(input int dly, input logic [31:0] rd,
                           output logic we, output logic [15:0] addr, output logic [31:0] wd);
    int n;
    n = 0;
    while (!bus.mem_req && n < 50) begin
      step();
      n++;
    end
    if (!bus.mem_req) check("mem_req_wait", {63'd0, bus.mem_req}, 64'd1);
    we   = bus.mem_we;
    addr = bus.mem_addr;
    wd   = bus.mem_wdata;
    repeat (dly) step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  logic        s_we;
  logic [15:0] s_addr;
  logic [31:0] s_wd;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.miss_req = 0; bus.miss_addr = '0;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    // Reset then idle
    repeat (2) step();
    check("rst_mem_req",    bus.mem_req,    0);
    check("rst_fill_valid", bus.fill_valid, 0);
    check("rst_miss_ready", bus.miss_ready, 1);
    check("rst_wr_ready",   bus.wr_ready,   1);
    check("rst_busy",       bus.busy,       0);
    reset = 1'b1;
    step();

    // Clean miss, ack 3 cycles after mem_req
    bus.miss_req = 1; bus.miss_addr = 16'h1203;
    check("miss_ready_idle", bus.miss_ready, 1);
    step();
    bus.miss_req = 0;
    check("miss_ready_check", bus.miss_ready, 0);
    check("busy_check", bus.busy, 1);
    step();
    check("rd_req",  bus.mem_req,  1);
    check("rd_we",   bus.mem_we,   0);
    check("rd_addr", bus.mem_addr, 16'h1203);
    repeat (3) step();
    check("rd_req_hold",  bus.mem_req,  1);
    check("rd_addr_hold", bus.mem_addr, 16'h1203);
    check("no_fill_early", bus.fill_valid, 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    check("fill_valid", bus.fill_valid, 1);
    check("fill_index", bus.fill_index, 4'h3);
    check("fill_tag",   bus.fill_tag,   8'h12);
    check("fill_data",  bus.fill_data,  32'hDEAD_BEEF);
    check("rd_req_drop", bus.mem_req,   0);
    step();
    check("fill_one_cycle", bus.fill_valid, 0);
    check("miss_ready_back", bus.miss_ready, 1);

    // Buffer full: four stores with ack held low
    for (int i = 0; i < 4; i++) begin
      bus.wr_req = 1; bus.wr_addr = 16'(16'h0100 + i); bus.wr_data = 32'(32'h1000_0000 + i);
      check("wr_ready_pre", bus.wr_ready, 1);
      step();
    end
    bus.wr_addr = 16'h01FF; bus.wr_data = 32'hFFFF_FFFF;
    check("wr_ready_full", bus.wr_ready, 0);
    repeat (2) step();
    check("wr_ready_full_hold", bus.wr_ready, 0);
    bus.wr_req = 0;
    for (int i = 0; i < 4; i++) begin
      mem_serve(1, 32'h0, s_we, s_addr, s_wd);
      check("wb_we",    s_we,   1);
      check("wb_addr",  s_addr, 16'(16'h0100 + i));
      check("wb_wdata", s_wd,   32'(32'h1000_0000 + i));
    end
    repeat (3) step();
    check("wb_no_fifth", bus.mem_req,  0);
    check("wb_busy",     bus.busy,     0);
    check("wb_ready",    bus.wr_ready, 1);

    // RAW hazard: store and miss to 0x0005 accepted together
    bus.wr_req = 1; bus.wr_addr = 16'h0005; bus.wr_data = 32'hA5A5_A5A5;
    bus.miss_req = 1; bus.miss_addr = 16'h0005;
    step();
    bus.wr_req = 0; bus.miss_req = 0;
`ifdef CACHE_RAW_FWD_EN
    step();
    check("fwd_fill_valid", bus.fill_valid, 1);
    check("fwd_fill_data",  bus.fill_data,  32'hA5A5_A5A5);
    check("fwd_fill_index", bus.fill_index, 4'h5);
    check("fwd_no_mem",     bus.mem_req,    0);
    mem_serve(0, 32'h0, s_we, s_addr, s_wd);
    check("fwd_wr_we",    s_we,   1);
    check("fwd_wr_addr",  s_addr, 16'h0005);
    check("fwd_wr_wdata", s_wd,   32'hA5A5_A5A5);
    repeat (3) step();
    check("fwd_no_read", bus.mem_req, 0);
    check("fwd_idle",    bus.busy,    0);
`else
    mem_serve(2, 32'h0, s_we, s_addr, s_wd);
    check("raw_wr_we",    s_we,   1);
    check("raw_wr_addr",  s_addr, 16'h0005);
    check("raw_wr_wdata", s_wd,   32'hA5A5_A5A5);
    mem_serve(1, 32'h5A5A_0001, s_we, s_addr, s_wd);
    check("raw_rd_we",   s_we,   0);
    check("raw_rd_addr", s_addr, 16'h0005);
    check("raw_fill_valid", bus.fill_valid, 1);
    check("raw_fill_data",  bus.fill_data,  32'h5A5A_0001);
    check("raw_fill_index", bus.fill_index, 4'h5);
    check("raw_fill_tag",   bus.fill_tag,   8'h00);
    step();
    check("raw_idle", bus.busy, 0);
`endif

    // Reset while a read is outstanding
    bus.miss_req = 1; bus.miss_addr = 16'h0777;
    step();
    bus.miss_req = 0;
    for (int n = 0; n < 20 && !bus.mem_req; n++) step();
    check("mid_rd_req", bus.mem_req, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_req",   bus.mem_req,    0);
    check("mid_rst_fill",  bus.fill_valid, 0);
    check("mid_rst_busy",  bus.busy,       0);
    check("mid_rst_ready", bus.miss_ready, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    step();
    check("stray_ack_fill", bus.fill_valid, 0);
    check("stray_ack_req",  bus.mem_req,    0);
    check("stray_ack_busy", bus.busy,       0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
